// File: rtl/npu_ahb_pkg.sv
// Shared AHB encodings, register map and bus-FSM state type for the NPU slave interface.
package npu_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HS_BYTE = 3'b000,
        HS_HALF = 3'b001,
        HS_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Register word index (haddr[3:2]) inside the 16-byte register block
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_CYCLES = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_PIX_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/npu_reg_file.sv
// NPU control/status storage: start pulse, sticky done/err, latched class and run-cycle counter.
module npu_reg_file
    import npu_ahb_pkg::*;
#(
    parameter int CLASS_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ctrl_we_i,
    input  logic [31:0]        wdata_i,
    input  logic [1:0]         rd_sel_i,
    output logic [31:0]        rdata_o,
    output logic               npu_start_o,
    input  logic               npu_busy_i,
    input  logic               npu_done_i,
    input  logic [CLASS_W-1:0] npu_class_i
);

    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               run_q, run_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [31:0]        cyc_q, cyc_d;

    logic start_req, start_ok, start_bad, clr;
    logic unused_wdata;

    assign unused_wdata = ^wdata_i[31:2];

    assign start_req = ctrl_we_i & wdata_i[CTRL_START];
    assign start_ok  = start_req & ~npu_busy_i;
    assign start_bad = start_req & npu_busy_i;
    assign clr       = ctrl_we_i & wdata_i[CTRL_CLR];

    // A done pulse always wins over a clear arriving in the same cycle
    always_comb begin
        start_d = start_ok;
        done_d  = done_q;
        if (npu_done_i)          done_d = 1'b1;
        else if (start_ok | clr) done_d = 1'b0;
        err_d = err_q;
        if (start_bad)  err_d = 1'b1;
        else if (clr)   err_d = 1'b0;
        class_d = npu_done_i ? npu_class_i : class_q;
        run_d   = run_q;
        if (start_ok)        run_d = 1'b1;
        else if (npu_done_i) run_d = 1'b0;
        cyc_d = cyc_q;
        if (start_ok)                       cyc_d = '0;
        else if (run_q && cyc_q != '1)      cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            class_q <= '0;
            cyc_q   <= '0;
        end else begin
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            run_q   <= run_d;
            class_q <= class_d;
            cyc_q   <= cyc_d;
        end
    end

    assign npu_start_o = start_q;

    always_comb begin
        rdata_o = '0;
        case (rd_sel_i)
            REG_STATUS: begin
                rdata_o[STAT_BUSY] = npu_busy_i;
                rdata_o[STAT_DONE] = done_q;
                rdata_o[STAT_ERR]  = err_q;
            end
            REG_RESULT: rdata_o = 32'(class_q);
            REG_CYCLES: rdata_o = cyc_q;
            default:    rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/npu_ahb_slave_if.sv
// AHB-Lite slave front-end: decodes transfers into NPU registers or the pixel window,
// stretches pixel accesses until ack, and returns two-cycle ERROR for illegal transfers.
module npu_ahb_slave_if
    import npu_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [12:0] PIX_OFFSET  = 13'h1000,
    parameter int          CLASS_W     = 5,
    parameter int          PIX_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        ahb_s0_haddr_i,
    input  logic               ahb_s0_hwrite_i,
    input  logic [2:0]         ahb_s0_hsize_i,
    input  logic [2:0]         ahb_s0_hburst_i,
    input  logic [3:0]         ahb_s0_hprot_i,
    input  logic [1:0]         ahb_s0_htrans_i,
    input  logic               ahb_s0_hmastlock_i,
    input  logic [31:0]        ahb_s0_hwdata_i,
    output logic               ahb_s0_hready_o,
    output logic               ahb_s0_hresp_o,
    output logic [31:0]        ahb_s0_hrdata_o,
    output logic               npu_start_o,
    input  logic               npu_busy_i,
    input  logic               npu_done_i,
    input  logic [CLASS_W-1:0] npu_class_i,
    output logic               pix_req_o,
    output logic               pix_we_o,
    output logic [9:0]         pix_addr_o,
    output logic [31:0]        pix_wdata_o,
    input  logic [31:0]        pix_rdata_i,
    input  logic               pix_ack_i
);

    localparam int TW = $clog2(PIX_TIMEOUT) + 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(PIX_TIMEOUT - 1);

    state_e        state_q, state_d, next_xfer;
    logic [1:0]    reg_sel_q, reg_sel_d;
    logic [9:0]    pix_idx_q, pix_idx_d;
    logic          write_q, write_d;
    logic [TW-1:0] wait_q, wait_d;

    logic        accept, base_hit, in_pix, in_reg, bad;
    logic [12:0] off, pix_rel;
    logic        ctrl_we;
    logic [31:0] reg_rdata;
    logic        unused_in;

    assign unused_in = ^{ahb_s0_hburst_i, ahb_s0_hprot_i, ahb_s0_hmastlock_i,
                         ahb_s0_htrans_i[0], pix_rel[1:0]};

    // Address-phase decode; each beat of a burst stands on its own
    always_comb begin
        accept   = ahb_s0_hready_o & ahb_s0_htrans_i[1];
        base_hit = ahb_s0_haddr_i[31:13] == BASE_ADDR[31:13];
        off      = ahb_s0_haddr_i[12:0];
        pix_rel  = off - PIX_OFFSET;
        in_pix   = base_hit && (off >= PIX_OFFSET) && !pix_rel[12];
        in_reg   = base_hit && !in_pix && (off[12:4] == 9'd0);
        bad      = (ahb_s0_hsize_i != HS_WORD) || (ahb_s0_haddr_i[1:0] != 2'b00) ||
                   !(in_pix || in_reg) ||
                   (in_reg && ahb_s0_hwrite_i && off[3:2] != REG_CTRL);
        if (!accept)     next_xfer = ST_IDLE;
        else if (bad)    next_xfer = ST_ERR1;
        else if (in_pix) next_xfer = ST_PIX_WAIT;
        else             next_xfer = ST_REG;
        reg_sel_d = accept ? off[3:2]        : reg_sel_q;
        pix_idx_d = accept ? pix_rel[11:2]   : pix_idx_q;
        write_d   = accept ? ahb_s0_hwrite_i : write_q;
        wait_d    = (state_q == ST_PIX_WAIT && !pix_ack_i) ? wait_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            reg_sel_q <= '0;
            pix_idx_q <= '0;
            write_q   <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            reg_sel_q <= reg_sel_d;
            pix_idx_q <= pix_idx_d;
            write_q   <= write_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d = next_xfer;
        case (state_q)
            ST_ERR1:     state_d = ST_ERR2;
            ST_PIX_WAIT: begin
                if (!pix_ack_i) state_d = (wait_q == WAIT_LAST) ? ST_ERR1 : ST_PIX_WAIT;
            end
            default:     state_d = next_xfer;
        endcase
    end

    // Pixel ack feeds hready/hrdata combinationally so the data phase ends in the ack cycle
    always_comb begin
        ahb_s0_hready_o = 1'b1;
        ahb_s0_hresp_o  = HRESP_OKAY;
        ahb_s0_hrdata_o = '0;
        pix_req_o       = 1'b0;
        pix_we_o        = 1'b0;
        pix_addr_o      = '0;
        pix_wdata_o     = '0;
        case (state_q)
            ST_REG: begin
                if (!write_q) ahb_s0_hrdata_o = reg_rdata;
            end
            ST_PIX_WAIT: begin
                pix_req_o       = 1'b1;
                pix_we_o        = write_q;
                pix_addr_o      = pix_idx_q;
                pix_wdata_o     = write_q ? ahb_s0_hwdata_i : 32'd0;
                ahb_s0_hready_o = pix_ack_i;
                if (pix_ack_i && !write_q) ahb_s0_hrdata_o = pix_rdata_i;
            end
            ST_ERR1: begin
                ahb_s0_hready_o = 1'b0;
                ahb_s0_hresp_o  = HRESP_ERROR;
            end
            ST_ERR2: ahb_s0_hresp_o = HRESP_ERROR;
            default: ;
        endcase
    end

    assign ctrl_we = (state_q == ST_REG) && write_q && (reg_sel_q == REG_CTRL);

    npu_reg_file #(.CLASS_W(CLASS_W)) u_regs (
        .clk         (clk),
        .resetn      (resetn),
        .ctrl_we_i   (ctrl_we),
        .wdata_i     (ahb_s0_hwdata_i),
        .rd_sel_i    (reg_sel_q),
        .rdata_o     (reg_rdata),
        .npu_start_o (npu_start_o),
        .npu_busy_i  (npu_busy_i),
        .npu_done_i  (npu_done_i),
        .npu_class_i (npu_class_i)
    );

endmodule

// File: tb/tb_npu_ahb_slave_if.sv
// Directed bench: a pipelined AHB master pushes expected responses; a negedge monitor checks them.
module tb_npu_ahb_slave_if;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic        hwrite = 1'b0, hmastlock = 1'b0;
    logic [2:0]  hsize = 3'b010, hburst = '0;
    logic [3:0]  hprot = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        npu_start, npu_busy = 1'b0, npu_done = 1'b0;
    logic [4:0]  npu_class = '0;
    logic        pix_req, pix_we, pix_ack = 1'b0;
    logic [9:0]  pix_addr;
    logic [31:0] pix_wdata, pix_rdata = 32'h1234_5678;

    always #5 clk = ~clk;

    npu_ahb_slave_if dut (
        .clk(clk), .resetn(resetn),
        .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite), .ahb_s0_hsize_i(hsize),
        .ahb_s0_hburst_i(hburst), .ahb_s0_hprot_i(hprot), .ahb_s0_htrans_i(htrans),
        .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
        .ahb_s0_hready_o(hready), .ahb_s0_hresp_o(hresp), .ahb_s0_hrdata_o(hrdata),
        .npu_start_o(npu_start), .npu_busy_i(npu_busy), .npu_done_i(npu_done),
        .npu_class_i(npu_class),
        .pix_req_o(pix_req), .pix_we_o(pix_we), .pix_addr_o(pix_addr),
        .pix_wdata_o(pix_wdata), .pix_rdata_i(pix_rdata), .pix_ack_i(pix_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        resp;
        logic [31:0] rdata;
        logic        chk;
        int          waits;
        int          id;
    } tx_t;

    tx_t tx_q[$];
    tx_t sb_q[$];
    int  n_tests = 0, n_fail = 0, n_id = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] wd, input logic rsp, input logic [31:0] rd,
                       input logic chk, input int waits);
        tx_t t;
        t.addr = a; t.write = w; t.size = s; t.wdata = wd; t.resp = rsp;
        t.rdata = rd; t.chk = chk; t.waits = waits; t.id = n_id++;
        tx_q.push_back(t);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!hready && n < 300) begin n++; @(negedge clk); end
        if (!hready) begin
            n_tests++; n_fail++;
            $display("FAIL hready_timeout: hready=0 after 300 cycles, expected 1");
        end
    endtask

    // Pipelined master: next address phase overlaps the current data phase
    task automatic run();
        tx_t t;
        @(posedge clk); #1;
        while (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            haddr = t.addr; hwrite = t.write; hsize = t.size; htrans = 2'b10;
            sb_q.push_back(t);
            wait_ready();
            @(posedge clk); #1;
            hwdata = t.write ? t.wdata : 32'd0;
        end
        htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b010;
        wait_ready();
        @(posedge clk); #1;
    endtask

    // Monitor: counts wait states of each data phase and scores it on completion
    logic in_dp = 1'b0, lwr = 1'b0, early = 1'b0;
    int   waits = 0, start_hi = 0;
    initial forever begin
        tx_t e;
        @(negedge clk);
        if (npu_start) start_hi++;
        if (!resetn) begin
            in_dp = 1'b0; waits = 0; lwr = 1'b0; early = 1'b0;
        end else begin
            if (in_dp) begin
                if (hready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_dphase: completion with empty scoreboard, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("x%0d_resp", e.id), 32'(hresp), 32'(e.resp));
                        check($sformatf("x%0d_waits", e.id), waits, e.waits);
                        if (waits > 0) check($sformatf("x%0d_wait_resp", e.id), 32'(lwr), 32'(e.resp));
                        check($sformatf("x%0d_early_err", e.id), 32'(early), 32'd0);
                        if (e.chk) check($sformatf("x%0d_rdata", e.id), hrdata, e.rdata);
                    end
                    in_dp = 1'b0; waits = 0; lwr = 1'b0; early = 1'b0;
                end else begin
                    if (lwr) early = 1'b1;
                    lwr = hresp;
                    waits++;
                end
            end
            if (hready && htrans[1]) in_dp = 1'b1;
        end
    end

    // Pixel-buffer model: ack after pix_delay request cycles; -1 never acks
    int pix_delay = 0, req_run = 0, last_req_len = 0;
    logic [9:0]  cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_wdata = '0;
    initial forever begin
        @(posedge clk); #1;
        pix_ack = 1'b0;
        if (pix_req) begin
            req_run++;
            if (pix_delay >= 0 && req_run == pix_delay + 1) begin
                pix_ack = 1'b1; last_req_len = req_run; req_run = 0;
            end
        end else begin
            if (req_run > 0) last_req_len = req_run;
            req_run = 0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (pix_req && pix_ack) begin cap_addr = pix_addr; cap_we = pix_we; cap_wdata = pix_wdata; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_start", 32'(npu_start), 32'd0);
        check("rst_pix_req", 32'(pix_req), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'd0, 1'b1, 0);
        run();

        // Accepted start, done after 100 counted cycles with class 5
        add(BASE + 32'h00, 1'b1, 3'b010, 32'd1, 1'b0, 32'd0, 1'b0, 0);
        run();
        check("start_pulse", 32'(npu_start), 32'd1);
        npu_busy = 1'b1;
        repeat (100) @(negedge clk);
        npu_done = 1'b1; npu_class = 5'd5;
        @(negedge clk);
        npu_done = 1'b0; npu_busy = 1'b0;
        check("start_count", start_hi, 1);
        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'h2, 1'b1, 0);
        add(BASE + 32'h08, 1'b0, 3'b010, 0, 1'b0, 32'd5, 1'b1, 0);
        add(BASE + 32'h0C, 1'b0, 3'b010, 0, 1'b0, 32'd100, 1'b1, 0);
        run();

        pix_delay = 3;
        add(BASE + 32'h1004, 1'b1, 3'b010, 32'hA5A5_0001, 1'b0, 32'd0, 1'b0, 3);
        run();
        check("pix_w_addr", 32'(cap_addr), 32'd1);
        check("pix_w_we", 32'(cap_we), 32'd1);
        check("pix_w_data", cap_wdata, 32'hA5A5_0001);
        pix_delay = 2;
        add(BASE + 32'h1008, 1'b0, 3'b010, 0, 1'b0, 32'h1234_5678, 1'b1, 2);
        run();
        check("pix_r_addr", 32'(cap_addr), 32'd2);
        check("pix_r_we", 32'(cap_we), 32'd0);

        add(BASE + 32'h00, 1'b1, 3'b000, 32'd1, 1'b1, 32'd0, 1'b0, 1);
        run();
        add(BASE + 32'h10, 1'b0, 3'b010, 0, 1'b1, 32'd0, 1'b0, 1);
        run();
        add(BASE + 32'h02, 1'b0, 3'b010, 0, 1'b1, 32'd0, 1'b0, 1);
        run();
        add(BASE + 32'h04, 1'b1, 3'b010, 32'd0, 1'b1, 32'd0, 1'b0, 1);
        run();
        check("no_start_on_err", start_hi, 1);

        // Pixel timeout: 64 wait cycles, then ERR1/ERR2
        pix_delay = -1;
        add(BASE + 32'h1000, 1'b0, 3'b010, 0, 1'b1, 32'd0, 1'b0, 65);
        run();
        check("pix_timeout_req_len", last_req_len, 64);
        pix_delay = 0;

        npu_busy = 1'b1;
        add(BASE + 32'h00, 1'b1, 3'b010, 32'd1, 1'b0, 32'd0, 1'b0, 0);
        run();
        npu_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_start_ignored", start_hi, 1);
        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'h6, 1'b1, 0);
        add(BASE + 32'h00, 1'b1, 3'b010, 32'd2, 1'b0, 32'd0, 1'b0, 0);
        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'h0, 1'b1, 0);
        run();

        // done held across a clr_done write: set wins
        npu_done = 1'b1; npu_class = 5'd9;
        add(BASE + 32'h00, 1'b1, 3'b010, 32'd2, 1'b0, 32'd0, 1'b0, 0);
        run();
        npu_done = 1'b0;
        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'h2, 1'b1, 0);
        add(BASE + 32'h08, 1'b0, 3'b010, 0, 1'b0, 32'd9, 1'b1, 0);
        add(BASE + 32'h0C, 1'b0, 3'b010, 0, 1'b0, 32'd100, 1'b1, 0);
        run();

        // Reset asserted during PIX_WAIT
        pix_delay = -1;
        @(posedge clk); #1;
        haddr = BASE + 32'h1000; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
        @(posedge clk); #1;
        htrans = 2'b00; haddr = '0;
        @(posedge clk); #1;
        check("pre_rst_pix_req", 32'(pix_req), 32'd1);
        check("pre_rst_hready", 32'(hready), 32'd0);
        resetn = 1'b0;
        #1;
        check("midrst_pix_req", 32'(pix_req), 32'd0);
        check("midrst_hready", 32'(hready), 32'd1);
        check("midrst_hresp", 32'(hresp), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        pix_delay = 0;
        add(BASE + 32'h04, 1'b0, 3'b010, 0, 1'b0, 32'h0, 1'b1, 0);
        add(BASE + 32'h08, 1'b0, 3'b010, 0, 1'b0, 32'h0, 1'b1, 0);
        add(BASE + 32'h0C, 1'b0, 3'b010, 0, 1'b0, 32'h0, 1'b1, 0);
        run();

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
